ats21_cmd_sched: RTL and testbench
==================================

Name: ats21_cmd_sched

Overview:
- Two-client command scheduler in front of the ATS21 timer/alarm block.
- Queues 32-bit commands from client A and client B, and splits each into the two 16-bit beats ATS21 expects on ctrlA/ctrlB with req.
- Resolves same-target conflicts itself, so ATS21 never Nacks both lanes for a collision.
- Samples the per-lane stat bit and returns one response per command to the issuing client.

Parameters:
- FIFO_DEPTH, 4, command queue entries per client (power of 2, >=2).
- MAX_RETRY, 2, reissue attempts after a Nack (used only with ATS21_RETRY_EN).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset (asserted at 0)
- a_cmd_valid  in  1  client A command valid
- a_cmd  in  32  client A command, opcode in [31:29]
- a_cmd_ready  out  1  client A queue not full
- a_rsp_valid  out  1  client A response valid, held until a_rsp_ack
- a_rsp_ok  out  1  1 = Ack, 0 = Nack/dropped
- a_rsp_ack  in  1  client A consumes response
- b_cmd_valid, b_cmd, b_cmd_ready, b_rsp_valid, b_rsp_ok, b_rsp_ack  same for client B
- req  out  1  to ATS21 req
- ctrlA  out  16  to ATS21 ctrlA
- ctrlB  out  16  to ATS21 ctrlB
- stat  in  2  from ATS21; [0] lane A, [1] lane B

Behaviour:
- Reset (reset=0, async):
  - req=0, ctrlA=ctrlB=0, rsp_valid=0, rsp_ok=0, cmd_ready=1.
  - Queues emptied, FSM to IDLE, priority pointer to A.
  - Mid-slot reset abandons the slot; no response is produced.
- Enqueue: cmd pushed on valid&&ready. cmd_ready=0 when FIFO_DEPTH entries are held.
- Opcode 000 and opcode 100 are never issued:
  - When at the queue head, popped in IDLE with rsp_valid=1, rsp_ok=0.
  - This costs one cycle for that lane and counts as that lane's slot.
- A lane is eligible when its queue is non-empty and its rsp_valid=0. Pending responses block that lane only.
- Conflict: both heads eligible and any of the following:
  - Both opcode 001/010 with equal opcode and equal [28:25].
  - Both in {101,110} with equal [28:24].
  - Both 111 with equal [28:24].
  - Both 011.
- On conflict, only the priority lane issues. The other lane's ctrl stays 0 for the whole slot. Priority toggles after every conflicted slot.
- FSM, one shared slot, 3 cycles:
  - IDLE: if any lane eligible, go to HI.
  - HI: req=1; ctrlX=cmd[31:16] for each issuing lane, 0 otherwise. Go to LO.
  - LO: req=1; ctrlX=cmd[15:0]. Go to RESP.
  - RESP: req=0, ctrl=0. Sample stat for each issuing lane, pop its queue, set rsp_valid. Go to IDLE.
- Issue latency: first HI cycle begins the cycle after a command reaches the head of an idle scheduler. Response is visible 4 cycles after the IDLE decision cycle.
- Back-to-back slots have at least one IDLE cycle between RESP and the next HI. This guarantees ATS21 sees req low and re-arms its beat counter.
- Opcodes 011 and 111 do not update ATS21 stat. For these, rsp_ok=1 without sampling.
- Response handshake: rsp_valid/rsp_ok are held stable until rsp_ack; they clear on the cycle after ack. An ack while rsp_valid=0 is ignored.
- Simultaneous enqueue and pop on a full queue: the pop frees space next cycle only. cmd_ready stays 0 that cycle.

Optional Feature:
- Macro ATS21_RETRY_EN.
- Defined:
  - A sampled Nack on opcodes 001/010/101/110 leaves the command at the queue head with a per-lane retry count incremented. No response is produced.
  - The lane reissues in the next slot.
  - After MAX_RETRY reissues still Nack, the command is popped with rsp_ok=0. The retry count clears on pop.
- Undefined: every sampled Nack responds immediately with rsp_ok=0; no retry counter is built.

Test Plan:
- Single A command 0x2A40_0100 (set clock 5, rate 01, count 0x0100) with stat[0]=1 in RESP -> HI: ctrlA=0x2A40, req=1; LO: ctrlA=0x0100; a_rsp_ok=1; ctrlB=0 throughout.
- A=0xA000_0010 and B=0xC000_0020 (alarm 0 / timer 0) together -> conflict: A issues alone, B issues next slot, B wins the following conflict; both rsp_ok reflect stat.
- A=0x2200_0000 (clock 1) and B=0x2400_0000 (clock 2) together -> single slot with both lanes driven, both responses in the same cycle.
- Push 5 commands to A with FIFO_DEPTH=4 and a_rsp_ack held 0 -> a_cmd_ready=0 after 4; after the first response only one slot, no further issue until ack.
- Opcode 000 command -> no req pulse, a_rsp_ok=0 one cycle later. Reset driven low during LO -> req=0 immediately, no response, queues empty.
- With ATS21_RETRY_EN and MAX_RETRY=2, stat[0]=0 always -> 3 slots issued for one command, then a_rsp_ok=0. Without the macro -> 1 slot, rsp_ok=0.

Source files
------------

// File: rtl/ats21_cmd_sched.sv
// ats21_cmd_sched: two-client command scheduler in front of the ATS21 timer/alarm block.
//
// Each client pushes 32-bit commands into its own queue. The scheduler runs one shared
// three-cycle slot (HI beat, LO beat, response) and issues the head command of every
// eligible lane whose target does not collide with the other lane. Opcodes 000/100 are
// retired without touching ATS21. One response per command goes back to the issuing client.
//
// Ports:
//   clk, reset (async, active-low)
//   a_cmd_valid/a_cmd[31:0]/a_cmd_ready       client A command queue push
//   a_rsp_valid/a_rsp_ok/a_rsp_ack            client A response, held until ack
//   b_*                                       same for client B
//   req, ctrlA[15:0], ctrlB[15:0]             beats towards ATS21
//   stat[1:0]                                 per-lane Ack/Nack from ATS21 ([0]=A, [1]=B)
//
// Optional build macro ATS21_RETRY_EN: Nacked commands stay queued and are reissued up to
// MAX_RETRY times before being retired with rsp_ok=0.
module ats21_cmd_sched #(
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_RETRY  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_cmd_valid,
  input  logic [31:0] a_cmd,
  output logic        a_cmd_ready,
  output logic        a_rsp_valid,
  output logic        a_rsp_ok,
  input  logic        a_rsp_ack,
  input  logic        b_cmd_valid,
  input  logic [31:0] b_cmd,
  output logic        b_cmd_ready,
  output logic        b_rsp_valid,
  output logic        b_rsp_ok,
  input  logic        b_rsp_ack,
  output logic        req,
  output logic [15:0] ctrlA,
  output logic [15:0] ctrlB,
  input  logic [1:0]  stat
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam bit CFG_OK = (FIFO_DEPTH >= 2) && ((FIFO_DEPTH & (FIFO_DEPTH - 1)) == 0)
                          && (MAX_RETRY >= 0);

  generate
    if (!CFG_OK) begin : g_cfg_check
      $error("ats21_cmd_sched: FIFO_DEPTH must be a power of 2 >= 2, MAX_RETRY >= 0");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_HI, S_LO, S_RESP} state_t;

  // Opcodes that are retired in IDLE without being issued.
  function automatic logic f_is_drop(input logic [2:0] op);
    return (op == 3'b000) || (op == 3'b100);
  endfunction

  // Opcodes for which ATS21 does not update stat; they always complete with Ack.
  function automatic logic f_no_stat(input logic [2:0] op);
    return (op == 3'b011) || (op == 3'b111);
  endfunction

  // Same-target collision between the two head commands.
  function automatic logic f_conflict(input logic [31:0] ca, input logic [31:0] cb);
    logic [2:0] opa;
    logic [2:0] opb;
    opa = ca[31:29];
    opb = cb[31:29];
    if ((opa == 3'b001 || opa == 3'b010) && (opa == opb) && (ca[28:25] == cb[28:25]))
      return 1'b1;
    if ((opa == 3'b101 || opa == 3'b110) && (opb == 3'b101 || opb == 3'b110)
        && (ca[28:24] == cb[28:24]))
      return 1'b1;
    if ((opa == 3'b111) && (opb == 3'b111) && (ca[28:24] == cb[28:24]))
      return 1'b1;
    if ((opa == 3'b011) && (opb == 3'b011))
      return 1'b1;
    return 1'b0;
  endfunction

  logic [1:0]  w_cmd_valid;
  logic [1:0]  w_rsp_ack;
  logic [1:0]  w_cmd_ready;
  logic [1:0]  w_push;
  logic [1:0]  w_pop;
  logic [1:0]  w_nonempty;
  logic [1:0]  w_elig;
  logic [1:0]  w_drop;
  logic [1:0]  w_issuable;
  logic [1:0]  w_ok_sample;
  logic [1:0]  w_rsp_set;
  logic [1:0]  w_ok_val;
  logic [1:0]  w_iss_next;
  logic [31:0] w_cmd_in [2];
  logic [31:0] w_head   [2];
  logic [15:0] w_ctrl   [2];
  logic        w_conflict;
  logic        w_load_iss;
  state_t      w_next;

  logic [1:0]  r_rsp_valid;
  logic [1:0]  r_rsp_ok;
  logic [1:0]  r_iss;
  logic        r_prio;
  state_t      r_state;

`ifdef ATS21_RETRY_EN
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);
  localparam logic [RW-1:0] RETRY_ONE   = RW'(1);
  logic [RW-1:0] r_retry [2];
  logic [1:0]    w_retry_inc;
`endif

  assign w_cmd_valid = {b_cmd_valid, a_cmd_valid};
  assign w_rsp_ack   = {b_rsp_ack, a_rsp_ack};
  assign w_cmd_in[0] = a_cmd;
  assign w_cmd_in[1] = b_cmd;

  generate
    for (genvar g = 0; g < 2; g++) begin : g_lane
      logic [31:0]   r_mem [FIFO_DEPTH];
      logic [AW-1:0] r_wp;
      logic [AW-1:0] r_rp;
      logic [AW:0]   r_cnt;

      // Ready follows the registered count, so a pop on a full queue frees space next cycle.
      assign w_cmd_ready[g] = (r_cnt != CNT_FULL);
      assign w_push[g]      = w_cmd_valid[g] & w_cmd_ready[g];
      assign w_nonempty[g]  = (r_cnt != '0);
      assign w_head[g]      = r_mem[r_rp];

      assign w_elig[g]      = w_nonempty[g] & ~r_rsp_valid[g];
      assign w_drop[g]      = w_elig[g] & f_is_drop(w_head[g][31:29]);
      assign w_issuable[g]  = w_elig[g] & ~f_is_drop(w_head[g][31:29]);
      assign w_ok_sample[g] = f_no_stat(w_head[g][31:29]) | stat[g];

      assign w_ctrl[g] = !r_iss[g]           ? 16'h0000 :
                         (r_state == S_HI)   ? w_head[g][31:16] :
                         (r_state == S_LO)   ? w_head[g][15:0] : 16'h0000;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_wp  <= '0;
          r_rp  <= '0;
          r_cnt <= '0;
        end else begin
          if (w_push[g]) r_wp <= r_wp + PTR_ONE;
          if (w_pop[g])  r_rp <= r_rp + PTR_ONE;
          case ({w_push[g], w_pop[g]})
            2'b10:   r_cnt <= r_cnt + CNT_ONE;
            2'b01:   r_cnt <= r_cnt - CNT_ONE;
            default: r_cnt <= r_cnt;
          endcase
        end
      end

      always_ff @(posedge clk) begin
        if (w_push[g]) r_mem[r_wp] <= w_cmd_in[g];
      end
    end
  endgenerate

  assign w_conflict = (&w_issuable) & f_conflict(w_head[0], w_head[1]);
  assign w_iss_next = !w_conflict ? w_issuable : (r_prio ? 2'b10 : 2'b01);

  always_comb begin
    w_next     = r_state;
    w_pop      = '0;
    w_rsp_set  = '0;
    w_ok_val   = '0;
    w_load_iss = 1'b0;
`ifdef ATS21_RETRY_EN
    w_retry_inc = '0;
`endif
    unique case (r_state)
      S_IDLE: begin
        // Dropped opcodes retire here and use up their lane's slot.
        w_pop     = w_drop;
        w_rsp_set = w_drop;
        if (|w_issuable) begin
          w_load_iss = 1'b1;
          w_next     = S_HI;
        end
      end
      S_HI: w_next = S_LO;
      S_LO: w_next = S_RESP;
      S_RESP: begin
        w_next = S_IDLE;
        for (int g = 0; g < 2; g++) begin
          if (r_iss[g]) begin
`ifdef ATS21_RETRY_EN
            if (!w_ok_sample[g] && (r_retry[g] != RETRY_LIMIT)) begin
              w_retry_inc[g] = 1'b1;
            end else begin
              w_pop[g]     = 1'b1;
              w_rsp_set[g] = 1'b1;
              w_ok_val[g]  = w_ok_sample[g];
            end
`else
            w_pop[g]     = 1'b1;
            w_rsp_set[g] = 1'b1;
            w_ok_val[g]  = w_ok_sample[g];
`endif
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_iss       <= '0;
      r_prio      <= 1'b0;
      r_rsp_valid <= '0;
      r_rsp_ok    <= '0;
    end else begin
      r_state <= w_next;
      if (w_load_iss) begin
        r_iss <= w_iss_next;
        if (w_conflict) r_prio <= ~r_prio;
      end
      for (int g = 0; g < 2; g++) begin
        if (w_rsp_set[g]) begin
          r_rsp_valid[g] <= 1'b1;
          r_rsp_ok[g]    <= w_ok_val[g];
        end else if (r_rsp_valid[g] && w_rsp_ack[g]) begin
          r_rsp_valid[g] <= 1'b0;
          r_rsp_ok[g]    <= 1'b0;
        end
      end
    end
  end

`ifdef ATS21_RETRY_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_retry[0] <= '0;
      r_retry[1] <= '0;
    end else begin
      for (int g = 0; g < 2; g++) begin
        if (w_retry_inc[g])  r_retry[g] <= r_retry[g] + RETRY_ONE;
        else if (w_pop[g])   r_retry[g] <= '0;
      end
    end
  end
`endif

  assign req         = (r_state == S_HI) || (r_state == S_LO);
  assign ctrlA       = w_ctrl[0];
  assign ctrlB       = w_ctrl[1];
  assign a_cmd_ready = w_cmd_ready[0];
  assign b_cmd_ready = w_cmd_ready[1];
  assign a_rsp_valid = r_rsp_valid[0];
  assign b_rsp_valid = r_rsp_valid[1];
  assign a_rsp_ok    = r_rsp_ok[0];
  assign b_rsp_ok    = r_rsp_ok[1];

endmodule

// File: tb/tb_ats21_cmd_sched.sv
// Bench for ats21_cmd_sched: ATS21 responder, scoreboard queues per client, directed
// scenarios followed by a randomized run.
module tb_ats21_cmd_sched;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        a_cmd_valid = 1'b0;
  logic [31:0] a_cmd = '0;
  logic        a_cmd_ready;
  logic        a_rsp_valid;
  logic        a_rsp_ok;
  logic        a_rsp_ack = 1'b0;
  logic        b_cmd_valid = 1'b0;
  logic [31:0] b_cmd = '0;
  logic        b_cmd_ready;
  logic        b_rsp_valid;
  logic        b_rsp_ok;
  logic        b_rsp_ack = 1'b0;
  logic        req;
  logic [15:0] ctrlA;
  logic [15:0] ctrlB;
  logic [1:0]  stat = 2'b00;

  always #5 clk = ~clk;

  ats21_cmd_sched dut (
    .clk(clk), .reset(reset),
    .a_cmd_valid(a_cmd_valid), .a_cmd(a_cmd), .a_cmd_ready(a_cmd_ready),
    .a_rsp_valid(a_rsp_valid), .a_rsp_ok(a_rsp_ok), .a_rsp_ack(a_rsp_ack),
    .b_cmd_valid(b_cmd_valid), .b_cmd(b_cmd), .b_cmd_ready(b_cmd_ready),
    .b_rsp_valid(b_rsp_valid), .b_rsp_ok(b_rsp_ok), .b_rsp_ack(b_rsp_ack),
    .req(req), .ctrlA(ctrlA), .ctrlB(ctrlB), .stat(stat)
  );

  int checks = 0;
  int errors = 0;
  int ack_mode = 1;          // 0: never ack, 1: always ack, 2: random ack

  logic [31:0] qa[$];        // accepted commands, client order
  logic [31:0] qb[$];
  logic        ea[$];        // expected rsp_ok, pushed on acceptance
  logic        eb[$];
  logic [1:0]  slot_log[$];  // lanes driven in each observed slot, bit0 = A

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_evt(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=event required=none t=%0t", name, $time);
  endtask

  // ATS21 answers Ack unless bit 15 of the low beat is set; stat-less opcodes always Ack,
  // dropped opcodes always Nack. A repeated Nack gives the same final answer with retries.
  function automatic logic exp_ok(input logic [31:0] c);
    logic [2:0] op;
    op = c[31:29];
    if (op == 3'd0 || op == 3'd4) return 1'b0;
    if (op == 3'd3 || op == 3'd7) return 1'b1;
    return ~c[15];
  endfunction

  function automatic logic collide(input logic [31:0] a, input logic [31:0] b);
    case (a[31:29])
      3'd1, 3'd2: return (b[31:29] == a[31:29]) && (a[28:25] == b[28:25]);
      3'd5, 3'd6: return (b[31:29] == 3'd5 || b[31:29] == 3'd6) && (a[28:24] == b[28:24]);
      3'd7:       return (b[31:29] == 3'd7) && (a[28:24] == b[28:24]);
      3'd3:       return (b[31:29] == 3'd3);
      default:    return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] rand_cmd();
    logic [2:0]  op;
    logic [1:0]  tgt;
    logic [23:0] low;
    op  = 3'($urandom_range(0, 7));
    tgt = 2'($urandom_range(0, 3));
    low = 24'($urandom);
    return {op, 3'b000, tgt, low};
  endfunction

  // Response acknowledge driver.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ack_mode)
        0:       begin a_rsp_ack = 1'b0; b_rsp_ack = 1'b0; end
        1:       begin a_rsp_ack = 1'b1; b_rsp_ack = 1'b1; end
        default: begin
          a_rsp_ack = 1'($urandom_range(0, 1));
          b_rsp_ack = 1'($urandom_range(0, 1));
        end
      endcase
    end
  end

  // ATS21 responder and beat checker: captures both beats of each req pulse, sets stat
  // during the LO beat, and checks the issued words against the client queue heads.
  initial begin
    int beats;
    logic [15:0] hi_a;
    logic [15:0] hi_b;
    logic [1:0]  mask;
    beats = 0;
    hi_a = '0;
    hi_b = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        beats = 0;
        stat = 2'b00;
      end else if (req) begin
        if (beats == 0) begin
          hi_a = ctrlA;
          hi_b = ctrlB;
        end else if (beats == 1) begin
          stat = ~{ctrlB[15], ctrlA[15]};
          mask = {hi_b != 16'h0, hi_a != 16'h0};
          if (mask[0]) begin
            if (qa.size() == 0) fail_evt("issueA_unexpected");
            else chk("issueA", {hi_a, ctrlA}, qa[0]);
          end else chk("quietA", {16'h0, ctrlA}, 32'h0);
          if (mask[1]) begin
            if (qb.size() == 0) fail_evt("issueB_unexpected");
            else chk("issueB", {hi_b, ctrlB}, qb[0]);
          end else chk("quietB", {16'h0, ctrlB}, 32'h0);
          if (mask == 2'b11) chk("no_collision", 32'(collide({hi_a, ctrlA}, {hi_b, ctrlB})), 0);
          chk("slot_has_lane", 32'(mask != 2'b00), 1);
          slot_log.push_back(mask);
        end
        beats++;
      end else begin
        if (beats != 0) chk("req_pulse_len", beats, 2);
        beats = 0;
      end
    end
  end

  // Response scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (reset && a_rsp_valid && a_rsp_ack) begin
        if (ea.size() == 0) fail_evt("rspA_unexpected");
        else begin
          chk("rspA_ok", 32'(a_rsp_ok), 32'(ea.pop_front()));
          void'(qa.pop_front());
        end
      end
      if (reset && b_rsp_valid && b_rsp_ack) begin
        if (eb.size() == 0) fail_evt("rspB_unexpected");
        else begin
          chk("rspB_ok", 32'(b_rsp_ok), 32'(eb.pop_front()));
          void'(qb.pop_front());
        end
      end
    end
  end

  // Presents commands on the lanes selected; returns at posedge+1 after the last acceptance.
  task automatic push_pair(input logic va, input logic vb, input logic [31:0] ca, input logic [31:0] cb);
    logic pa;
    logic pb;
    int n;
    pa = va;
    pb = vb;
    n = 0;
    a_cmd_valid = pa;
    a_cmd = ca;
    b_cmd_valid = pb;
    b_cmd = cb;
    while ((pa || pb) && n < 300) begin
      @(negedge clk);
      if (pa && a_cmd_ready) begin qa.push_back(ca); ea.push_back(exp_ok(ca)); pa = 1'b0; end
      if (pb && b_cmd_ready) begin qb.push_back(cb); eb.push_back(exp_ok(cb)); pb = 1'b0; end
      @(posedge clk);
      #1;
      a_cmd_valid = pa;
      b_cmd_valid = pb;
      n++;
    end
    if (pa || pb) fail_evt("push_timeout");
    a_cmd_valid = 1'b0;
    b_cmd_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((qa.size() != 0 || qb.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain_done", 32'(n < budget), 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_slots;
    logic va;
    logic vb;

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_req", 32'(req), 0);
    chk("rst_ctrl", {ctrlA, ctrlB}, 0);
    chk("rst_rsp", {28'h0, a_rsp_valid, a_rsp_ok, b_rsp_valid, b_rsp_ok}, 0);
    chk("rst_ready", {30'h0, a_cmd_ready, b_cmd_ready}, 3);
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Single A command: beat timing and contents.
    ack_mode = 1;
    push_pair(1'b1, 1'b0, 32'h2A40_0100, 32'h0);
    @(negedge clk);
    chk("t1_idle_req", 32'(req), 0);
    @(negedge clk);
    chk("t1_hi", {15'h0, req, ctrlA}, {15'h0, 1'b1, 16'h2A40});
    chk("t1_hi_b", 32'(ctrlB), 0);
    @(negedge clk);
    chk("t1_lo", {15'h0, req, ctrlA}, {15'h0, 1'b1, 16'h0100});
    chk("t1_lo_b", 32'(ctrlB), 0);
    @(negedge clk);
    chk("t1_resp_req", 32'(req), 0);
    @(negedge clk);
    chk("t1_rsp", {30'h0, a_rsp_valid, a_rsp_ok}, 3);
    drain(200);

    // Alarm 0 vs timer 0 collide twice: A first, then B, then B wins, then A.
    slot_log.delete();
    push_pair(1'b1, 1'b1, 32'hA000_0010, 32'hC000_0020);
    drain(200);
    push_pair(1'b1, 1'b1, 32'hA000_0010, 32'hC000_0020);
    drain(200);
    chk("t2_slots", slot_log.size(), 4);
    if (slot_log.size() == 4)
      chk("t2_order", {24'h0, slot_log[0], slot_log[1], slot_log[2], slot_log[3]}, 32'b01_10_10_01);

    // Different clocks: one shared slot, both responses together.
    slot_log.delete();
    push_pair(1'b1, 1'b1, 32'h2200_0000, 32'h2400_0000);
    repeat (4) @(negedge clk);
    @(negedge clk);
    chk("t3_both_rsp", {30'h0, a_rsp_valid, b_rsp_valid}, 3);
    drain(200);
    chk("t3_slots", slot_log.size(), 1);
    if (slot_log.size() == 1) chk("t3_mask", 32'(slot_log[0]), 3);

    // Queue full with responses held back.
    ack_mode = 0;
    slot_log.delete();
    for (int i = 0; i < 4; i++) push_pair(1'b1, 1'b0, 32'h2200_0001 + 32'(i), 32'h0);
    @(negedge clk);
    chk("t4_full_ready", 32'(a_cmd_ready), 0);
    @(posedge clk);
    #1;
    push_pair(1'b1, 1'b0, 32'h2200_0005, 32'h0);
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("t4_one_slot", slot_log.size(), 1);
    chk("t4_rsp_held", {30'h0, a_rsp_valid, a_rsp_ok}, 3);
    @(posedge clk);
    #1;
    ack_mode = 1;
    drain(500);
    chk("t4_total_slots", slot_log.size(), 5);

    // Opcode 000 is retired without a req pulse.
    ack_mode = 0;
    slot_log.delete();
    push_pair(1'b1, 1'b0, 32'h0000_1234, 32'h0);
    @(negedge clk);
    chk("t5_not_yet", 32'(a_rsp_valid), 0);
    @(negedge clk);
    chk("t5_drop_rsp", {30'h0, a_rsp_valid, a_rsp_ok}, 2);
    @(posedge clk);
    #1;
    ack_mode = 1;
    drain(200);
    chk("t5_no_slot", slot_log.size(), 0);

    // Reset during the LO beat abandons the slot.
    push_pair(1'b1, 1'b0, 32'h2A40_0100, 32'h0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("t6_in_lo", {15'h0, req, ctrlA}, {15'h0, 1'b1, 16'h0100});
    reset = 1'b0;
    #1;
    chk("t6_req_drop", {15'h0, req, ctrlA}, 0);
    qa.delete();
    ea.delete();
    @(posedge clk);
    #1;
    reset = 1'b1;
    chk("t6_ready", {30'h0, a_cmd_ready, b_cmd_ready}, 3);
    slot_log.delete();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t6_no_rsp", {30'h0, a_rsp_valid, req}, 0);
    end
    chk("t6_no_slot", slot_log.size(), 0);
    @(posedge clk);
    #1;

    // Persistent Nack.
    slot_log.delete();
    push_pair(1'b1, 1'b0, 32'h2200_8000, 32'h0);
    drain(300);
`ifdef ATS21_RETRY_EN
    exp_slots = 3;
`else
    exp_slots = 1;
`endif
    chk("t7_nack_slots", slot_log.size(), exp_slots);

    // Randomized traffic.
    ack_mode = 2;
    for (int i = 0; i < 150; i++) begin
      va = ($urandom_range(0, 2) == 0);
      vb = ($urandom_range(0, 2) == 0);
      if (va || vb) push_pair(va, vb, rand_cmd(), rand_cmd());
      else begin
        @(posedge clk);
        #1;
      end
    end
    ack_mode = 1;
    drain(5000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
